// File: rtl/sram_bus_ctrl_if.sv
// Request/response and SRAM pad bundle for sram_bus_ctrl.
// slave = the controller, master = the requester plus whatever models the SRAM pins.
interface sram_bus_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_* must be stable while req_valid is high and not yet accepted. rsp_valid
  // is a single-cycle pulse with no back-pressure.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_cen;
  logic              sram_wen;
  logic              sram_oen;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;
  logic [1:0]        dbg_state;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, sram_dq_i,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output sram_addr, sram_cen, sram_wen, sram_oen, sram_dq_o, sram_dq_oe,
    output dbg_state
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, sram_dq_i,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  sram_addr, sram_cen, sram_wen, sram_oen, sram_dq_o, sram_dq_oe,
    input  dbg_state
  );
endinterface

// File: rtl/sram_bus_ctrl.sv
// Turns one valid/ready request into a CE/WE/OE SRAM cycle with registered strobes.
// Optional SRAM_CTRL_POSTED_WR_EN: writes acknowledge right after accept; strobe timing unchanged.
module sram_bus_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 2,
  parameter int T_HOLD  = 1
) (
  input logic           clk,
  input logic           rst,
  sram_bus_ctrl_if.slave bus
);

  localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX    = (T_MAX_SP > T_HOLD) ? T_MAX_SP : T_HOLD;
  localparam int CNT_W    = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(T_HOLD - 1);

`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam bit POSTED_WR = 1'b1;
`else
  localparam bit POSTED_WR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_o_q;
  logic [DATA_W-1:0] rdata_q;
  logic              cen_q;
  logic              wen_q;
  logic              oen_q;
  logic              dq_oe_q;
  logic              rsp_valid_q;

  // Each phase reloads cnt with its length minus one and advances when it hits zero,
  // so a phase of N cycles ends exactly N edges after it was entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      rdata_q     <= '0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      oen_q       <= 1'b1;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            dq_o_q      <= bus.req_wdata;
            we_q        <= bus.req_we;
            cen_q       <= 1'b0;
            dq_oe_q     <= bus.req_we;
            cnt         <= SETUP_LOAD;
            state       <= SETUP;
            rsp_valid_q <= POSTED_WR & bus.req_we;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            if (we_q) wen_q <= 1'b0;
            else      oen_q <= 1'b0;
            cnt   <= PULSE_LOAD;
            state <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          // Read data is sampled on the same edge that raises OE, while the SRAM still drives.
          if (cnt == '0) begin
            wen_q <= 1'b1;
            oen_q <= 1'b1;
            if (!we_q) rdata_q <= bus.sram_dq_i;
            cnt   <= HOLD_LOAD;
            state <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cen_q       <= 1'b1;
            dq_oe_q     <= 1'b0;
            rsp_valid_q <= ~(POSTED_WR & we_q);
            state       <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_cen   = cen_q;
  assign bus.sram_wen   = wen_q;
  assign bus.sram_oen   = oen_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Directed bench for sram_bus_ctrl: default-parameter instance plus a wide/slow instance,
// each attached to a behavioural asynchronous SRAM.
module tb_sram_bus_ctrl;

`ifdef SRAM_CTRL_POSTED_WR_EN
  localparam int WR0_RSP = 0;
  localparam int WR1_RSP = 0;
`else
  localparam int WR0_RSP = 4;
  localparam int WR1_RSP = 7;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_bus_ctrl_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
  sram_bus_ctrl_if #(.ADDR_W(10), .DATA_W(16)) b1 ();

  sram_bus_ctrl u0 (.clk(clk), .rst(rst), .bus(b0));
  sram_bus_ctrl #(.ADDR_W(10), .DATA_W(16), .T_SETUP(1), .T_PULSE(4), .T_HOLD(2))
    u1 (.clk(clk), .rst(rst), .bus(b1));

  // Asynchronous SRAM models: write latched on WE rising with CE low, read while CE&OE low.
  logic [7:0]  mem0 [256];
  logic [15:0] mem1 [1024];

  always @(posedge b0.sram_wen)
    if (!b0.sram_cen && b0.sram_dq_oe) mem0[b0.sram_addr] <= b0.sram_dq_o;
  always @(posedge b1.sram_wen)
    if (!b1.sram_cen && b1.sram_dq_oe) mem1[b1.sram_addr] <= b1.sram_dq_o;

  assign b0.sram_dq_i = (!b0.sram_cen && !b0.sram_oen) ? mem0[b0.sram_addr] : 8'h00;
  assign b1.sram_dq_i = (!b1.sram_cen && !b1.sram_oen) ? mem1[b1.sram_addr] : 16'h0000;

  typedef struct {
    logic        cen, wen, oen, oe, rv, ready, busy;
    logic [15:0] addr, dq_o, rdata;
  } samp_t;

  samp_t tr [32];
  int    n;
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock, then a sample 1 ns after the edge into tr[n] (index k = edges since the first step).
  task automatic step(input int sel);
    @(posedge clk);
    #1;
    if (n < 32) begin
      if (sel == 0) begin
        tr[n].cen = b0.sram_cen;  tr[n].wen = b0.sram_wen;  tr[n].oen = b0.sram_oen;
        tr[n].oe = b0.sram_dq_oe; tr[n].rv = b0.rsp_valid;  tr[n].ready = b0.req_ready;
        tr[n].busy = b0.busy;     tr[n].addr = 16'(b0.sram_addr);
        tr[n].dq_o = 16'(b0.sram_dq_o); tr[n].rdata = 16'(b0.rsp_rdata);
      end else begin
        tr[n].cen = b1.sram_cen;  tr[n].wen = b1.sram_wen;  tr[n].oen = b1.sram_oen;
        tr[n].oe = b1.sram_dq_oe; tr[n].rv = b1.rsp_valid;  tr[n].ready = b1.req_ready;
        tr[n].busy = b1.busy;     tr[n].addr = 16'(b1.sram_addr);
        tr[n].dq_o = b1.sram_dq_o; tr[n].rdata = b1.rsp_rdata;
      end
      n++;
    end
  endtask

  // f: 0 cen low, 1 wen low, 2 oen low, 3 dq_oe high, 4 rsp_valid, 5 strobe rule broken
  function automatic logic fld(input int f, input int i);
    case (f)
      0: return !tr[i].cen;
      1: return !tr[i].wen;
      2: return !tr[i].oen;
      3: return tr[i].oe;
      4: return tr[i].rv;
      default: return (!tr[i].wen && !tr[i].oen) || (tr[i].cen && (!tr[i].wen || !tr[i].oen));
    endcase
  endfunction

  function automatic int cnt_fld(input int f);
    int c = 0;
    for (int i = 0; i < n; i++) if (fld(f, i)) c++;
    return c;
  endfunction

  function automatic int first_fld(input int f);
    for (int i = 0; i < n; i++) if (fld(f, i)) return i;
    return -1;
  endfunction

  // Samples 0..last where addr/dq_o differ from the latched request.
  function automatic int unstable(input int last, input logic [15:0] a, input logic [15:0] d, input bit chk_d);
    int c = 0;
    for (int i = 0; i <= last && i < n; i++)
      if (tr[i].addr !== a || (chk_d && tr[i].dq_o !== d)) c++;
    return c;
  endfunction

  task automatic req0(input logic we, input logic [7:0] a, input logic [7:0] d);
    b0.req_valid = 1'b1; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d;
  endtask

  initial begin
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cen", 32'(b0.sram_cen), 1);
    chk("rst_wen_oen", 32'({b0.sram_wen, b0.sram_oen}), 3);
    chk("rst_dq_oe", 32'(b0.sram_dq_oe), 0);
    chk("rst_ready_busy", 32'({b0.req_ready, b0.busy, b0.rsp_valid}), 32'b100);
    chk("rst_rdata_addr_dq", 32'({b0.rsp_rdata, b0.sram_addr, b0.sram_dq_o}), 0);
    rst = 1'b0;

    // Write 0x46 to 0x7F
    n = 0;
    req0(1'b1, 8'h7F, 8'h46);
    step(0);
    b0.req_valid = 1'b0;
    repeat (6) step(0);
    chk("wr_cen_low_cycles", cnt_fld(0), 4);
    chk("wr_cen_first", first_fld(0), 0);
    chk("wr_wen_low_cycles", cnt_fld(1), 2);
    chk("wr_wen_first", first_fld(1), 1);
    chk("wr_oen_low_cycles", cnt_fld(2), 0);
    chk("wr_dq_oe_cycles", cnt_fld(3), 4);
    chk("wr_dq_oe_first", first_fld(3), 0);
    chk("wr_strobe_rule", cnt_fld(5), 0);
    chk("wr_rsp_count", cnt_fld(4), 1);
    chk("wr_rsp_cycle", first_fld(4), WR0_RSP);
    chk("wr_addr_data_stable", unstable(3, 16'h007F, 16'h0046, 1'b1), 0);
    chk("wr_ready_low_in_hold", 32'({tr[3].ready, tr[3].busy}), 32'b01);
    chk("wr_rdata_unchanged", 32'(tr[6].rdata), 0);
    chk("wr_mem7f", 32'(mem0[8'h7F]), 32'h46);

    // Read 0x7F
    n = 0;
    req0(1'b0, 8'h7F, 8'h00);
    step(0);
    b0.req_valid = 1'b0;
    repeat (6) step(0);
    chk("rd_oen_low_cycles", cnt_fld(2), 2);
    chk("rd_oen_first", first_fld(2), 1);
    chk("rd_wen_low_cycles", cnt_fld(1), 0);
    chk("rd_dq_oe_cycles", cnt_fld(3), 0);
    chk("rd_strobe_rule", cnt_fld(5), 0);
    chk("rd_rsp_cycle", first_fld(4), 4);
    chk("rd_rdata_at_rsp", 32'(tr[4].rdata), 32'h46);
    chk("rd_rdata_held", 32'(tr[6].rdata), 32'h46);
    chk("rd_addr_stable", unstable(3, 16'h007F, 16'h0000, 1'b0), 0);

    // Held req_valid: write 0x10=0xA5, then read 0x10 back-to-back
    n = 0;
    req0(1'b1, 8'h10, 8'hA5);
    step(0);
    req0(1'b0, 8'h10, 8'h00);
    repeat (5) step(0);
    b0.req_valid = 1'b0;
    repeat (6) step(0);
    chk("b2b_rsp_count", cnt_fld(4), 2);
    chk("b2b_first_rsp", first_fld(4), WR0_RSP);
    chk("b2b_ready_in_gap", 32'({tr[4].ready, tr[4].cen, tr[5].cen}), 32'b110);
    chk("b2b_cen_low_cycles", cnt_fld(0), 8);
    chk("b2b_oen_first", first_fld(2), 6);
    chk("b2b_read_rsp", 32'({tr[9].rv, tr[9].rdata}), 32'h1_00A5);
    chk("b2b_strobe_rule", cnt_fld(5), 0);

    // Reset pulse in the middle of a write's WE pulse
    n = 0;
    req0(1'b1, 8'h20, 8'h5A);
    step(0);
    b0.req_valid = 1'b0;
    step(0);
    chk("abort_in_pulse", 32'(tr[1].wen), 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_strobes", 32'({b0.sram_cen, b0.sram_wen, b0.sram_oen, b0.sram_dq_oe}), 32'b1110);
    chk("abort_rsp_ready_busy", 32'({b0.rsp_valid, b0.req_ready, b0.busy}), 32'b010);
    chk("abort_state", 32'(b0.dbg_state), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    repeat (5) step(0);
    chk("abort_no_rsp", cnt_fld(4), 0);
    chk("abort_idle_cen", cnt_fld(0), 0);

    // Read 0x7F survives the aborted write elsewhere
    n = 0;
    req0(1'b0, 8'h7F, 8'h00);
    step(0);
    b0.req_valid = 1'b0;
    repeat (5) step(0);
    chk("post_abort_read", 32'({tr[4].rv, tr[4].rdata}), 32'h1_0046);

    // Wide/slow instance: write then read 0x3FF = 0xBEEF
    n = 0;
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 10'h3FF; b1.req_wdata = 16'hBEEF;
    step(1);
    b1.req_valid = 1'b0;
    repeat (9) step(1);
    chk("w_wr_wen_cycles", cnt_fld(1), 4);
    chk("w_wr_wen_first", first_fld(1), 1);
    chk("w_wr_cen_cycles", cnt_fld(0), 7);
    chk("w_wr_rsp_cycle", first_fld(4), WR1_RSP);
    chk("w_wr_strobe_rule", cnt_fld(5), 0);
    chk("w_wr_mem", 32'(mem1[10'h3FF]), 32'hBEEF);
    n = 0;
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 10'h3FF; b1.req_wdata = 16'h0000;
    step(1);
    b1.req_valid = 1'b0;
    repeat (9) step(1);
    chk("w_rd_oen_cycles", cnt_fld(2), 4);
    chk("w_rd_rsp_cycle", first_fld(4), 7);
    chk("w_rd_rdata", 32'(tr[7].rdata), 32'hBEEF);
    chk("w_rd_dq_oe", cnt_fld(3), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
